// File: rtl/detect_collector.sv
`default_nettype none
// ============================================================================
// Module   : detect_collector
// Purpose  : Collects one timestamp per detection channel within a window and
//            holds the result, with deltas against the first-captured channel.
// Revision : 1.0
// ============================================================================
module detect_collector #(
  parameter logic [31:0] TIMEOUT = 32'd100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_0,
  input  logic        valid_1,
  input  logic        valid_2,
  input  logic        valid_3,
  input  logic [31:0] detect_time_0,
  input  logic [31:0] detect_time_1,
  input  logic [31:0] detect_time_2,
  input  logic [31:0] detect_time_3,
  output logic        ack_0,
  output logic        ack_1,
  output logic        ack_2,
  output logic        ack_3,
  input  logic        rd_ack,
  output logic        result_valid,
  output logic [31:0] time_0,
  output logic [31:0] time_1,
  output logic [31:0] time_2,
  output logic [31:0] time_3,
  output logic [31:0] delta_0,
  output logic [31:0] delta_1,
  output logic [31:0] delta_2,
  output logic [31:0] delta_3,
  output logic [3:0]  ch_mask,
  output logic [1:0]  ref_ch,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [3:0]  w_valid;
  logic [31:0] w_dt [4];
  logic [3:0]  w_cap;
  logic [3:0]  w_drop;
  logic [3:0]  w_new_mask;
  logic [1:0]  w_first_ch;
  logic [31:0] w_ref_time;
  logic        w_timeout;
  logic [2:0]  w_drop_n;
  logic [8:0]  w_drop_sum;

  logic [31:0] r_time  [4];
  logic [31:0] r_delta [4];
  logic [3:0]  r_mask;
  logic [1:0]  r_ref_ch;
  logic [31:0] r_ref_time;
  logic [31:0] r_timer;
  logic [7:0]  r_drop;
  logic [3:0]  r_ack;
  logic        r_result_valid;

  assign w_valid = {valid_3, valid_2, valid_1, valid_0};
  assign w_dt[0] = detect_time_0;
  assign w_dt[1] = detect_time_1;
  assign w_dt[2] = detect_time_2;
  assign w_dt[3] = detect_time_3;

  always_comb begin
    w_cap  = 4'b0000;
    w_drop = 4'b0000;
    case (r_state)
      IDLE:    w_cap = w_valid;
      COLLECT: begin
        w_cap  = w_valid & ~r_mask;
        w_drop = w_valid & r_mask;
      end
      HOLD:    w_drop = w_valid;
      default: w_cap = 4'b0000;
    endcase
  end

  // Lowest-index channel in the opening capture cycle becomes the reference
  always_comb begin
    w_first_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_valid[i]) w_first_ch = 2'(i);
    end
  end

  assign w_ref_time = (r_state == IDLE) ? w_dt[w_first_ch] : r_ref_time;
  assign w_new_mask = r_mask | w_cap;
  assign w_timeout  = (r_timer == (TIMEOUT - 32'd1));
  assign w_drop_n   = {2'b00, w_drop[0]} + {2'b00, w_drop[1]}
                    + {2'b00, w_drop[2]} + {2'b00, w_drop[3]};
  assign w_drop_sum = {1'b0, r_drop} + {6'b000000, w_drop_n};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (|w_valid) w_next_state = (w_valid == 4'hF) ? HOLD : COLLECT;
      COLLECT: if ((w_new_mask == 4'hF) || w_timeout) w_next_state = HOLD;
      HOLD:    if (rd_ack) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack          <= 4'b0000;
      r_drop         <= 8'h00;
      r_result_valid <= 1'b0;
      r_timer        <= 32'd0;
      r_mask         <= 4'b0000;
      r_ref_ch       <= 2'd0;
      r_ref_time     <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        r_time[i]  <= 32'd0;
        r_delta[i] <= 32'd0;
      end
    end else begin
      r_ack          <= w_valid;
      r_drop         <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      r_result_valid <= (w_next_state == HOLD);
      if (r_state == COLLECT) r_timer <= r_timer + 32'd1;
      if ((r_state == IDLE) && (|w_valid)) begin
        r_timer    <= 32'd0;
        r_ref_ch   <= w_first_ch;
        r_ref_time <= w_ref_time;
      end
      if ((r_state == HOLD) && rd_ack) begin
        r_mask   <= 4'b0000;
        r_ref_ch <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          r_time[i]  <= 32'd0;
          r_delta[i] <= 32'd0;
        end
      end else begin
        r_mask <= w_new_mask;
        for (int i = 0; i < 4; i++) begin
          if (w_cap[i]) begin
            r_time[i]  <= w_dt[i];
            r_delta[i] <= w_dt[i] - w_ref_time;
          end
        end
      end
    end
  end

  assign ack_0        = r_ack[0];
  assign ack_1        = r_ack[1];
  assign ack_2        = r_ack[2];
  assign ack_3        = r_ack[3];
  assign result_valid = r_result_valid;
  assign time_0       = r_time[0];
  assign time_1       = r_time[1];
  assign time_2       = r_time[2];
  assign time_3       = r_time[3];
  assign delta_0      = r_delta[0];
  assign delta_1      = r_delta[1];
  assign delta_2      = r_delta[2];
  assign delta_3      = r_delta[3];
  assign ch_mask      = r_mask;
  assign ref_ch       = r_ref_ch;
  assign drop_cnt     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_detect_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_detect_collector
// Purpose  : Self-checking bench; two instances (long and short window) share
//            stimulus, acks are checked through an expected-ack queue.
// Revision : 1.0
// ============================================================================
module tb_detect_collector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             rd_ack = 1'b0;
  logic [3:0]       valid = 4'h0;
  logic [3:0][31:0] dt = '0;

  logic [3:0]       ack_a, ack_b, mask_a, mask_b;
  logic             rv_a, rv_b;
  logic [3:0][31:0] time_a, time_b, delta_a, delta_b;
  logic [1:0]       ref_a, ref_b;
  logic [7:0]       drop_a, drop_b;

  int total = 0;
  int bad   = 0;
  logic [3:0] ack_q[$];

  detect_collector #(.TIMEOUT(32'd100)) dut_a (
    .clk(clk), .rst(rst),
    .valid_0(valid[0]), .valid_1(valid[1]), .valid_2(valid[2]), .valid_3(valid[3]),
    .detect_time_0(dt[0]), .detect_time_1(dt[1]), .detect_time_2(dt[2]), .detect_time_3(dt[3]),
    .ack_0(ack_a[0]), .ack_1(ack_a[1]), .ack_2(ack_a[2]), .ack_3(ack_a[3]),
    .rd_ack(rd_ack), .result_valid(rv_a),
    .time_0(time_a[0]), .time_1(time_a[1]), .time_2(time_a[2]), .time_3(time_a[3]),
    .delta_0(delta_a[0]), .delta_1(delta_a[1]), .delta_2(delta_a[2]), .delta_3(delta_a[3]),
    .ch_mask(mask_a), .ref_ch(ref_a), .drop_cnt(drop_a)
  );

  detect_collector #(.TIMEOUT(32'd8)) dut_b (
    .clk(clk), .rst(rst),
    .valid_0(valid[0]), .valid_1(valid[1]), .valid_2(valid[2]), .valid_3(valid[3]),
    .detect_time_0(dt[0]), .detect_time_1(dt[1]), .detect_time_2(dt[2]), .detect_time_3(dt[3]),
    .ack_0(ack_b[0]), .ack_1(ack_b[1]), .ack_2(ack_b[2]), .ack_3(ack_b[3]),
    .rd_ack(rd_ack), .result_valid(rv_b),
    .time_0(time_b[0]), .time_1(time_b[1]), .time_2(time_b[2]), .time_3(time_b[3]),
    .delta_0(delta_b[0]), .delta_1(delta_b[1]), .delta_2(delta_b[2]), .delta_3(delta_b[3]),
    .ch_mask(mask_b), .ref_ch(ref_b), .drop_cnt(drop_b)
  );

  typedef struct {
    logic [3:0]       v;
    logic [3:0][31:0] t;
    logic             rv_a;
    logic [3:0]       m_a;
    logic             rv_b;
    logic [3:0]       m_b;
    logic [7:0]       d_b;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [3:0][31:0] tv(input int t0, input int t1, input int t2, input int t3);
    return {32'(t3), 32'(t2), 32'(t1), 32'(t0)};
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0][31:0] t,
                              input logic ra, input logic [3:0] ma,
                              input logic rb, input logic [3:0] mb, input logic [7:0] db);
    vec_t r;
    r.v = v; r.t = t; r.rv_a = ra; r.m_a = ma; r.rv_b = rb; r.m_b = mb; r.d_b = db;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (ack_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL ack_queue: got empty expected entry");
    end else begin
      e = ack_q.pop_front();
      chk("ack_a", 32'(ack_a), 32'(e));
      chk("ack_b", 32'(ack_b), 32'(e));
    end
  endtask

  task automatic apply(input logic [3:0] v, input logic [3:0][31:0] t, input logic rd);
    valid  = v;
    dt     = t;
    rd_ack = rd;
    ack_q.push_back(rst ? 4'h0 : v);
    tick();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    apply(4'h0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset with every input active: all outputs must be zero
    rst = 1'b1;
    apply(4'hF, tv(1, 2, 3, 4), 1'b1);
    apply(4'hF, tv(1, 2, 3, 4), 1'b1);
    chk("rst_rv", 32'({rv_a, rv_b}), 32'd0);
    chk("rst_mask", 32'({mask_a, mask_b}), 32'd0);
    chk("rst_ref_drop", 32'({ref_a, ref_b, drop_a, drop_b}), 32'd0);
    chk("rst_time_delta", 32'(|{time_a, time_b, delta_a, delta_b}), 32'd0);
    rst = 1'b0;

    // Staggered four-channel capture; the short-window instance times out at cycle 8
    tbl[0]  = mk(4'b0010, tv(0, 1000, 0, 0), 1'b0, 4'b0010, 1'b0, 4'b0010, 8'd0);
    tbl[1]  = mk(4'b0000, '0,               1'b0, 4'b0010, 1'b0, 4'b0010, 8'd0);
    tbl[2]  = mk(4'b0000, '0,               1'b0, 4'b0010, 1'b0, 4'b0010, 8'd0);
    tbl[3]  = mk(4'b0000, '0,               1'b0, 4'b0010, 1'b0, 4'b0010, 8'd0);
    tbl[4]  = mk(4'b0000, '0,               1'b0, 4'b0010, 1'b0, 4'b0010, 8'd0);
    tbl[5]  = mk(4'b1000, tv(0, 0, 0, 1250), 1'b0, 4'b1010, 1'b0, 4'b1010, 8'd0);
    tbl[6]  = mk(4'b0000, '0,               1'b0, 4'b1010, 1'b0, 4'b1010, 8'd0);
    tbl[7]  = mk(4'b0000, '0,               1'b0, 4'b1010, 1'b0, 4'b1010, 8'd0);
    tbl[8]  = mk(4'b0000, '0,               1'b0, 4'b1010, 1'b1, 4'b1010, 8'd0);
    tbl[9]  = mk(4'b0001, tv(900, 0, 0, 0), 1'b0, 4'b1011, 1'b1, 4'b1010, 8'd1);
    tbl[10] = mk(4'b0000, '0,               1'b0, 4'b1011, 1'b1, 4'b1010, 8'd1);
    tbl[11] = mk(4'b0000, '0,               1'b0, 4'b1011, 1'b1, 4'b1010, 8'd1);
    tbl[12] = mk(4'b0100, tv(0, 0, 1100, 0), 1'b1, 4'b1111, 1'b1, 4'b1010, 8'd2);
    tbl[13] = mk(4'b0000, '0,               1'b1, 4'b1111, 1'b1, 4'b1010, 8'd2);
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].v, tbl[i].t, 1'b0);
      chk($sformatf("tbl%0d_rv_a", i), 32'(rv_a), 32'(tbl[i].rv_a));
      chk($sformatf("tbl%0d_mask_a", i), 32'(mask_a), 32'(tbl[i].m_a));
      chk($sformatf("tbl%0d_rv_b", i), 32'(rv_b), 32'(tbl[i].rv_b));
      chk($sformatf("tbl%0d_mask_b", i), 32'(mask_b), 32'(tbl[i].m_b));
      chk($sformatf("tbl%0d_drop_b", i), 32'(drop_b), 32'(tbl[i].d_b));
    end
    chk("seq_ref_a", 32'(ref_a), 32'd1);
    chk("seq_delta0_a", delta_a[0], 32'hFFFFFF9C);
    chk("seq_delta1_a", delta_a[1], 32'd0);
    chk("seq_delta2_a", delta_a[2], 32'd100);
    chk("seq_delta3_a", delta_a[3], 32'd250);
    chk("seq_time0_a", time_a[0], 32'd900);
    chk("seq_time2_a", time_a[2], 32'd1100);
    chk("seq_drop_a", 32'(drop_a), 32'd0);
    chk("part_ref_b", 32'(ref_b), 32'd1);
    chk("part_time3_b", time_b[3], 32'd1250);
    chk("part_time0_b", time_b[0], 32'd0);
    chk("part_delta3_b", delta_b[3], 32'd250);
    chk("part_delta0_b", delta_b[0], 32'd0);

    // Held result must not move while idle in HOLD
    for (int i = 0; i < 3; i++) apply(4'h0, tv(7, 7, 7, 7), 1'b0);
    chk("hold_mask_a", 32'(mask_a), 32'hF);
    chk("hold_delta0_a", delta_a[0], 32'hFFFFFF9C);
    chk("hold_time3_a", time_a[3], 32'd1250);
    chk("hold_rv_a", 32'(rv_a), 32'd1);

    // rd_ack together with valid_1 in HOLD
    apply(4'b0010, tv(0, 5, 0, 0), 1'b1);
    chk("rdack_rv_a", 32'(rv_a), 32'd0);
    chk("rdack_mask_a", 32'(mask_a), 32'd0);
    chk("rdack_drop_a", 32'(drop_a), 32'd1);
    chk("rdack_drop_b", 32'(drop_b), 32'd3);
    chk("rdack_clear_a", 32'(|{time_a, delta_a}), 32'd0);
    chk("rdack_rv_b", 32'(rv_b), 32'd0);
    apply(4'h0, '0, 1'b1);
    chk("idle_rdack_rv_a", 32'(rv_a), 32'd0);

    // Single channel timing out on the short window
    apply(4'b0100, tv(0, 0, 500, 0), 1'b0);
    cnt = 0;
    for (int n = 1; n <= 20; n++) begin
      apply(4'h0, '0, (n == 3));
      if (rv_b) begin
        cnt = n;
        break;
      end
    end
    chk("tmo_cycles_b", 32'(cnt), 32'd8);
    chk("tmo_mask_b", 32'(mask_b), 32'b0100);
    chk("tmo_ref_b", 32'(ref_b), 32'd2);
    chk("tmo_time2_b", time_b[2], 32'd500);
    chk("tmo_deltas_b", 32'(|delta_b), 32'd0);
    chk("collect_rv_a", 32'(rv_a), 32'd0);
    chk("collect_mask_a", 32'(mask_a), 32'b0100);

    // Reset in the middle of a collection
    rst = 1'b1;
    apply(4'b0001, tv(3, 0, 0, 0), 1'b0);
    chk("midrst_mask_a", 32'(mask_a), 32'd0);
    chk("midrst_misc_a", 32'({rv_a, ref_a, drop_a, drop_b}), 32'd0);
    chk("midrst_time_a", 32'(|{time_a, delta_a}), 32'd0);
    rst = 1'b0;
    apply(4'b1000, tv(0, 0, 0, 77), 1'b0);
    chk("fresh_ref_a", 32'(ref_a), 32'd3);
    chk("fresh_mask_a", 32'(mask_a), 32'b1000);
    chk("fresh_time3_a", time_a[3], 32'd77);

    // All four channels in one IDLE cycle
    pulse_rst();
    apply(4'hF, tv(10, 20, 30, 40), 1'b0);
    chk("all4_rv_a", 32'(rv_a), 32'd1);
    chk("all4_rv_b", 32'(rv_b), 32'd1);
    chk("all4_ref_a", 32'(ref_a), 32'd0);
    chk("all4_d0", delta_a[0], 32'd0);
    chk("all4_d1", delta_a[1], 32'd10);
    chk("all4_d2", delta_a[2], 32'd20);
    chk("all4_d3", delta_a[3], 32'd30);

    // Repeats in COLLECT and HOLD, multi-drop cycles, saturation
    pulse_rst();
    apply(4'b0010, tv(0, 100, 0, 0), 1'b0);
    apply(4'b0001, tv(50, 0, 0, 0), 1'b0);
    apply(4'b0001, tv(60, 0, 0, 0), 1'b0);
    chk("dup_drop_a", 32'(drop_a), 32'd1);
    chk("dup_time0_a", time_a[0], 32'd50);
    apply(4'b1100, tv(0, 0, 70, 80), 1'b0);
    chk("dup_rv_a", 32'(rv_a), 32'd1);
    for (int i = 0; i < 3; i++) apply(4'b0001, tv(99, 0, 0, 0), 1'b0);
    chk("hold_drop_a", 32'(drop_a), 32'd4);
    chk("hold_drop_b", 32'(drop_b), 32'd4);
    chk("hold_time0_a", time_a[0], 32'd50);
    apply(4'hF, tv(1, 2, 3, 4), 1'b0);
    chk("multi_drop_a", 32'(drop_a), 32'd8);
    for (int i = 0; i < 61; i++) apply(4'hF, tv(1, 2, 3, 4), 1'b0);
    chk("near_sat_a", 32'(drop_a), 32'd252);
    apply(4'hF, tv(1, 2, 3, 4), 1'b0);
    chk("sat_a", 32'(drop_a), 32'hFF);
    apply(4'b0001, tv(1, 0, 0, 0), 1'b0);
    chk("sat_hold_a", 32'(drop_a), 32'hFF);
    chk("sat_b", 32'(drop_b), 32'hFF);
    chk("sat_mask_a", 32'(mask_a), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
